cdec8_dbg_mon: RTL and testbench
================================

# cdec8_dbg_mon

Host-side debug monitor for the CDEC8 core. Receives one-byte commands from a PC over an 8N1 serial line and drives the datapath's resource-address bus `resad`. It samples the returned `resdt` byte and transmits it back over serial, either as a single read or as a 16-entry dump. It sits at the top level beside the CDEC8 datapath, on the far end of the `resad`/`resdt` observation bus.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 8..65535.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset_N`  input  1  reset, synchronous, active-low.
- `rxd`  input  1  serial command input; asynchronous to `clock`; idles high.
- `txd`  output  1  serial response output; idles high.
- `resad`  output  8  resource address to the datapath debug bus.
- `resdt`  input  8  resource data returned by the datapath for `resad`.
- `busy`  output  1  high while a command is executing (SETUP through the last stop bit).
- `frm_err`  output  1  one-cycle pulse on a received stop bit of 0.
- `cmd_drop`  output  1  one-cycle pulse when a valid frame completes while `busy`=1.

## Operation
- Reset values: `txd`=1, `resad`=8'h00, `busy`=0, `frm_err`=0, `cmd_drop`=0; all FSMs in IDLE. Reset mid-frame or mid-dump aborts the activity with no partial output; `txd` is 1 from the edge at which reset is sampled.
- `rxd` passes through a 2-flop synchronizer. The receiver acts only on the synchronized value.
- **Receiver FSM: R_IDLE → R_START → R_DATA → R_STOP → R_IDLE.**
  - R_IDLE: a synchronized 1→0 edge starts the frame.
  - R_START: samples at `CLKS_PER_BIT/2` (integer divide). If the sample is 1, the event is a glitch: return to R_IDLE with no pulse.
  - R_DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first.
  - R_STOP: one sample `CLKS_PER_BIT` after the last data sample.
    - Stop = 0: pulse `frm_err` and discard the byte.
    - Stop = 1: the byte is a valid command.
- **Command decode (valid byte, `busy`=0):**
  - 8'h00..8'h0F: single read of that address.
  - 8'hFF: dump of addresses 8'h00 through 8'h0F in ascending order (16 responses).
  - Any other value: ignored, with no response and no pulse.
- A valid byte arriving while `busy`=1 is discarded and pulses `cmd_drop`. A framing error while busy pulses `frm_err` only. The receiver is never blocked.
- **Sequencer FSM: S_IDLE → S_SETUP → S_SAMPLE → S_SEND → S_WAIT → (S_SETUP | S_IDLE).**
  - S_SETUP: `resad` is loaded with the current address. `resad` stays stable until the next S_SETUP; it is not cleared in S_IDLE.
  - S_SAMPLE: one settle cycle. At its end, `resdt` is latched into the TX shift register.
  - S_SEND: starts the transmitter.
  - S_WAIT: waits for the transmitter to finish. In dump mode, if the address is below 8'h0F, the address increments and the FSM goes to S_SETUP; otherwise it goes to S_IDLE.
  - `busy` is 1 in every state except S_IDLE.
- **Transmitter:** sends start bit 0, 8 data bits LSB first, then stop bit 1, each held exactly `CLKS_PER_BIT` cycles (10×`CLKS_PER_BIT` per frame). `txd` is registered.
- `resdt` can carry Z/X for unmapped addresses (8'h0B, 8'h0C). The monitor transmits whatever it latched, with no special handling.

## Timing
- The command is accepted on the cycle after the stop-bit sample (cycle C). S_SETUP is in cycle C and `resad` is valid from C+1. `resdt` is latched at the end of C+1 (S_SAMPLE). The start bit is driven on `txd` from C+3.
- `busy` rises at C+1. It falls on the cycle after the final stop bit completes.
- Dump mode: the TX-done → S_SETUP → S_SAMPLE → S_SEND path puts exactly 3 idle-high cycles between consecutive frames. Total dump length is 16×(10×`CLKS_PER_BIT`+3)−3 cycles of `txd` activity.
- `frm_err` and `cmd_drop` are asserted in the cycle after the stop-bit sample, for exactly 1 cycle.
- Receiver latency from the `rxd` pin to the synchronized value is 2 cycles. Bit-sample instants are measured from the synchronized edge.

## Test plan
- `CLKS_PER_BIT`=16, `resdt` modeled as `resad`^8'hA5. Send 8'h03 → one frame carrying 8'hA6; `resad`=8'h03; `busy` high for 10×16+3 cycles ±1.
- Send 8'hFF → 16 frames carrying 8'hA5, 8'hA4 … 8'hAA, in address order 8'h00..8'h0F, with a 3-cycle gap between frames. `busy` falls after the 16th frame.
- Send 8'h01 with stop bit 0 → `frm_err` pulses once; no TX activity; `resad` unchanged.
- Send 8'hFF, then 8'h02 during the dump → `cmd_drop` pulses once; the dump completes unchanged; no extra frame follows.
- 3-cycle low glitch on `rxd` → no receive, no pulses. Send 8'h20 → ignored; `txd` stays 1.
- Assert `reset_N`=0 for 1 cycle mid-dump → next cycle `txd`=1, `busy`=0, `resad`=8'h00. A subsequent 8'h05 works normally and returns 8'hA0.

Source files
------------

// File: rtl/cdec8_dbg_mon.sv
`default_nettype none
// ============================================================================
// Module   : cdec8_dbg_mon
// Purpose  : 8N1 serial debug monitor; reads CDEC8 resources over resad/resdt.
// Revision : 1.0  initial release
// ============================================================================
module cdec8_dbg_mon #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset_N,
   input  logic       rxd,
   output logic       txd,
   output logic [7:0] resad,
   input  logic [7:0] resdt,
   output logic       busy,
   output logic       frm_err,
   output logic       cmd_drop
);
   localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] c_half_last = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SAMPLE, S_SEND, S_WAIT} seq_state_t;

   rx_state_t   r_rx_state;
   logic        r_rx_meta, r_rx_sync, r_rx_prev;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        r_rx_valid;

   seq_state_t  r_seq_state;
   logic [3:0]  r_addr;
   logic        r_dump;
   logic        r_tx_active;
   logic [15:0] r_tx_cnt;
   logic [3:0]  r_tx_bit;
   logic [8:0]  r_tx_shift;
   logic        w_tx_done;

   assign w_tx_done = r_tx_active && (r_tx_bit == 4'd9) && (r_tx_cnt == c_bit_last);

   // Receiver: bit instants are timed from the synchronized falling edge.
   always_ff @(posedge clock) begin
      if (!reset_N) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= R_IDLE;
         r_rx_cnt   <= 16'd0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'h00;
         r_rx_valid <= 1'b0;
         frm_err    <= 1'b0;
         cmd_drop   <= 1'b0;
      end else begin
         r_rx_meta  <= rxd;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         r_rx_valid <= 1'b0;
         frm_err    <= 1'b0;
         cmd_drop   <= 1'b0;
         case (r_rx_state)
            R_IDLE: begin
               if (r_rx_prev && !r_rx_sync) begin
                  r_rx_state <= R_START;
                  r_rx_cnt   <= 16'd0;
               end
            end
            R_START: begin
               if (r_rx_cnt == c_half_last) begin
                  r_rx_cnt   <= 16'd0;
                  r_rx_bit   <= 3'd0;
                  r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            R_DATA: begin
               if (r_rx_cnt == c_bit_last) begin
                  r_rx_cnt   <= 16'd0;
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                  if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
                  else                  r_rx_bit   <= r_rx_bit + 3'd1;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            R_STOP: begin
               if (r_rx_cnt == c_bit_last) begin
                  r_rx_cnt   <= 16'd0;
                  r_rx_state <= R_IDLE;
                  if (!r_rx_sync)  frm_err    <= 1'b1;
                  else if (busy)   cmd_drop   <= 1'b1;
                  else             r_rx_valid <= 1'b1;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            default: r_rx_state <= R_IDLE;
         endcase
      end
   end

   // Sequencer and transmitter; the idle-state accept performs the first setup
   // itself so resad is valid the cycle after the command is accepted.
   always_ff @(posedge clock) begin
      if (!reset_N) begin
         r_seq_state <= S_IDLE;
         r_addr      <= 4'h0;
         r_dump      <= 1'b0;
         resad       <= 8'h00;
         busy        <= 1'b0;
         txd         <= 1'b1;
         r_tx_active <= 1'b0;
         r_tx_cnt    <= 16'd0;
         r_tx_bit    <= 4'd0;
         r_tx_shift  <= 9'h1FF;
      end else begin
         if (r_tx_active) begin
            if (r_tx_cnt == c_bit_last) begin
               r_tx_cnt <= 16'd0;
               if (r_tx_bit == 4'd9) begin
                  r_tx_active <= 1'b0;
               end else begin
                  r_tx_bit   <= r_tx_bit + 4'd1;
                  txd        <= r_tx_shift[0];
                  r_tx_shift <= {1'b1, r_tx_shift[8:1]};
               end
            end else begin
               r_tx_cnt <= r_tx_cnt + 16'd1;
            end
         end

         case (r_seq_state)
            S_IDLE: begin
               if (r_rx_valid && (r_rx_shift <= 8'h0F)) begin
                  r_addr      <= r_rx_shift[3:0];
                  resad       <= r_rx_shift;
                  r_dump      <= 1'b0;
                  busy        <= 1'b1;
                  r_seq_state <= S_SAMPLE;
               end else if (r_rx_valid && (r_rx_shift == 8'hFF)) begin
                  r_addr      <= 4'h0;
                  resad       <= 8'h00;
                  r_dump      <= 1'b1;
                  busy        <= 1'b1;
                  r_seq_state <= S_SAMPLE;
               end
            end
            S_SETUP: begin
               resad       <= {4'h0, r_addr};
               r_seq_state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               r_tx_shift  <= {1'b1, resdt};
               r_seq_state <= S_SEND;
            end
            S_SEND: begin
               r_tx_active <= 1'b1;
               r_tx_cnt    <= 16'd0;
               r_tx_bit    <= 4'd0;
               txd         <= 1'b0;
               r_seq_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_tx_done) begin
                  if (r_dump && (r_addr != 4'hF)) begin
                     r_addr      <= r_addr + 4'd1;
                     r_seq_state <= S_SETUP;
                  end else begin
                     busy        <= 1'b0;
                     r_seq_state <= S_IDLE;
                  end
               end
            end
            default: begin
               busy        <= 1'b0;
               r_seq_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdec8_dbg_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdec8_dbg_mon
// Purpose  : Self-checking bench for cdec8_dbg_mon with a serial-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cdec8_dbg_mon;
   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB + 3;

   logic       clock = 1'b0;
   logic       reset_N;
   logic       rxd;
   logic       txd;
   logic [7:0] resad;
   logic [7:0] resdt;
   logic       busy;
   logic       frm_err;
   logic       cmd_drop;

   assign resdt = resad ^ 8'hA5;

   cdec8_dbg_mon #(.CLKS_PER_BIT(CPB)) dut (
      .clock    (clock),
      .reset_N  (reset_N),
      .rxd      (rxd),
      .txd      (txd),
      .resad    (resad),
      .resdt    (resdt),
      .busy     (busy),
      .frm_err  (frm_err),
      .cmd_drop (cmd_drop)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int epoch    = 0;
   int n_frm, n_drop, n_busy, busy_rise;
   logic prev_busy = 1'b0;
   logic [7:0] q_frames[$];
   int         q_start[$];

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (frm_err === 1'b1)  n_frm++;
      if (cmd_drop === 1'b1) n_drop++;
      if (busy === 1'b1)     n_busy++;
      if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise = cyc;
      prev_busy = busy;
   end

   // Serial decoder for txd: finds each start bit and samples mid-bit.
   int         m_start, m_epoch;
   logic [7:0] m_byte;
   logic       m_stop;
   always begin
      @(negedge clock);
      if (txd === 1'b0) begin
         m_start = cyc;
         m_epoch = epoch;
         repeat (CPB / 2) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            m_byte[i] = txd;
         end
         repeat (CPB) @(negedge clock);
         m_stop = txd;
         if (m_epoch == epoch) begin
            chk("tx_stop_bit", 32'(m_stop), 32'd1);
            q_frames.push_back(m_byte);
            q_start.push_back(m_start);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clear_obs();
      q_frames.delete();
      q_start.delete();
      n_frm = 0; n_drop = 0; n_busy = 0; busy_rise = -1000;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clock);
      rxd = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clock);
      end
      rxd = stop;
      repeat (CPB) @(negedge clock);
      rxd = 1'b1;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy === 1'b1 && n < bound) begin
         @(negedge clock);
         n++;
      end
      chk("idle_reached", 32'(n < bound), 32'd1);
      repeat (2 * CPB) @(negedge clock);
   endtask

   // Expected dump: addresses 0..15 in order, data = address ^ A5.
   task automatic check_dump();
      int gap_bad;
      logic [7:0] got;
      chk("dump_frames", 32'(q_frames.size()), 32'd16);
      for (int a = 0; a < 16; a++) begin
         got = (a < q_frames.size()) ? q_frames[a] : 8'h00;
         chk("dump_byte", 32'(got), 32'(8'(a) ^ 8'hA5));
      end
      gap_bad = 0;
      for (int i = 1; i < q_start.size(); i++)
         if (q_start[i] - q_start[i-1] != FRAME) gap_bad++;
      chk("dump_gaps_bad", 32'(gap_bad), 32'd0);
      chk_range("dump_busy_cycles", n_busy, 16 * FRAME - 2, 16 * FRAME);
      chk("dump_resad", 32'(resad), 32'h0F);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic       stop;
      int         nfr;
      logic [7:0] first;
      int         nfe;
      logic [7:0] ad;
   } vec_t;
   vec_t vecs[6];

   logic [7:0] exp_q[$];
   logic [7:0] rb, exp_ad, got;
   logic       rs;
   int         cls;

   initial begin
      repeat (90000) @(posedge clock);
      n_fail++;
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h03, 1'b1, 1, 8'hA6, 0, 8'h03};
      vecs[1] = '{8'h01, 1'b0, 0, 8'h00, 1, 8'h03};
      vecs[2] = '{8'h20, 1'b1, 0, 8'h00, 0, 8'h03};
      vecs[3] = '{8'h0F, 1'b1, 1, 8'hAA, 0, 8'h0F};
      vecs[4] = '{8'h00, 1'b1, 1, 8'hA5, 0, 8'h00};
      vecs[5] = '{8'h0B, 1'b1, 1, 8'hAE, 0, 8'h0B};

      reset_N = 1'b0;
      rxd     = 1'b1;
      clear_obs();
      repeat (5) @(negedge clock);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_resad", 32'(resad), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frm_err", 32'(frm_err), 32'd0);
      chk("rst_cmd_drop", 32'(cmd_drop), 32'd0);
      reset_N = 1'b1;
      repeat (4) @(negedge clock);

      for (int v = 0; v < 6; v++) begin
         clear_obs();
         send_byte(vecs[v].cmd, vecs[v].stop);
         wait_idle(4 * FRAME);
         chk("vec_frames", 32'(q_frames.size()), 32'(vecs[v].nfr));
         chk("vec_frm_err", 32'(n_frm), 32'(vecs[v].nfe));
         chk("vec_cmd_drop", 32'(n_drop), 32'd0);
         chk("vec_resad", 32'(resad), 32'(vecs[v].ad));
         if (vecs[v].nfr > 0) begin
            got = (q_frames.size() > 0) ? q_frames[0] : 8'h00;
            chk("vec_data", 32'(got), 32'(vecs[v].first));
            chk_range("vec_busy_cycles", n_busy, FRAME - 1, FRAME + 1);
            chk("vec_start_latency", 32'((q_start.size() > 0 ? q_start[0] : 0) - busy_rise), 32'd2);
         end else begin
            chk("vec_no_busy", 32'(n_busy), 32'd0);
         end
      end

      clear_obs();
      send_byte(8'hFF, 1'b1);
      wait_idle(20 * FRAME);
      check_dump();
      chk("dump_first_latency", 32'((q_start.size() > 0 ? q_start[0] : 0) - busy_rise), 32'd2);

      clear_obs();
      send_byte(8'hFF, 1'b1);
      send_byte(8'h02, 1'b1);
      wait_idle(20 * FRAME);
      check_dump();
      chk("drop_pulses", 32'(n_drop), 32'd1);
      chk("drop_frm_err", 32'(n_frm), 32'd0);

      clear_obs();
      @(negedge clock);
      rxd = 1'b0;
      repeat (3) @(negedge clock);
      rxd = 1'b1;
      repeat (4 * CPB) @(negedge clock);
      chk("glitch_frm_err", 32'(n_frm), 32'd0);
      chk("glitch_cmd_drop", 32'(n_drop), 32'd0);
      chk("glitch_frames", 32'(q_frames.size()), 32'd0);
      chk("glitch_busy", 32'(n_busy), 32'd0);

      clear_obs();
      send_byte(8'hFF, 1'b1);
      repeat (500) @(negedge clock);
      reset_N = 1'b0;
      epoch++;
      @(negedge clock);
      reset_N = 1'b1;
      chk("midrst_txd", 32'(txd), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_resad", 32'(resad), 32'h00);
      repeat (12 * CPB) @(negedge clock);
      clear_obs();
      send_byte(8'h05, 1'b1);
      wait_idle(4 * FRAME);
      chk("post_rst_frames", 32'(q_frames.size()), 32'd1);
      got = (q_frames.size() > 0) ? q_frames[0] : 8'h00;
      chk("post_rst_data", 32'(got), 32'hA0);
      chk("post_rst_resad", 32'(resad), 32'h05);

      // Randomized commands against the reference model.
      exp_ad = 8'h05;
      for (int k = 0; k < 10; k++) begin
         cls = $urandom_range(0, 9);
         rs  = 1'b1;
         if (cls <= 4)      rb = 8'($urandom_range(0, 15));
         else if (cls == 5) rb = 8'hFF;
         else if (cls == 6) begin rb = 8'($urandom_range(0, 255)); rs = 1'b0; end
         else               rb = 8'($urandom_range(0, 255));
         exp_q.delete();
         if (rs) begin
            if (rb <= 8'h0F) begin
               exp_q.push_back(rb ^ 8'hA5);
               exp_ad = rb;
            end else if (rb == 8'hFF) begin
               for (int a = 0; a < 16; a++) exp_q.push_back(8'(a) ^ 8'hA5);
               exp_ad = 8'h0F;
            end
         end
         clear_obs();
         send_byte(rb, rs);
         wait_idle(20 * FRAME);
         chk("rnd_frames", 32'(q_frames.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < q_frames.size(); i++)
            chk("rnd_data", 32'(q_frames[i]), 32'(exp_q[i]));
         chk("rnd_frm_err", 32'(n_frm), 32'(rs ? 0 : 1));
         chk("rnd_cmd_drop", 32'(n_drop), 32'd0);
         chk("rnd_resad", 32'(resad), 32'(exp_ad));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
